// File: rtl/act_pkg.sv
// Shared types and constants for the activation stage and its lane function.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package act_pkg;

  localparam int DEF_DATA_W  = 16;
  localparam int DEF_FRAC_W  = 8;
  localparam int ACT_SEL_W   = 3;
  // Negative-side slope of leaky ReLU is 2^-LEAKY_SHIFT (1/8).
  localparam int LEAKY_SHIFT = 3;

  // Codes 5..7 are reserved and fall through to identity.
  typedef enum logic [ACT_SEL_W-1:0] {
    ACT_IDENTITY = 3'd0,
    ACT_RELU     = 3'd1,
    ACT_LEAKY    = 3'd2,
    ACT_HSIGMOID = 3'd3,
    ACT_HTANH    = 3'd4
  } act_sel_t;

endpackage

// File: rtl/act_lane.sv
// Single-lane piecewise-linear activation (x, select -> y), signed fixed point.
// Latency: purely combinational.
// Backpressure: none; the caller registers the result.
module act_lane
  import act_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int FRAC_W = DEF_FRAC_W
) (
  input  logic signed [DATA_W-1:0]    x_i,
  input  logic        [ACT_SEL_W-1:0] act_sel_i,
  output logic        [DATA_W-1:0]    y_o
);

  localparam int ONE  = 1 << FRAC_W;
  localparam int HALF = ONE >> 1;

  // One extra bit of headroom so (x>>>2)+HALF and the tanh bounds cannot wrap.
  localparam logic signed [DATA_W:0] ONE_W     = (DATA_W+1)'(ONE);
  localparam logic signed [DATA_W:0] NEG_ONE_W = (DATA_W+1)'(-ONE);
  localparam logic signed [DATA_W:0] HALF_W    = (DATA_W+1)'(HALF);

  logic signed [DATA_W:0] ext;
  logic signed [DATA_W:0] sig_sum;

  // Select the activation; unknown/reserved codes pass x through unchanged.
  always_comb begin
    ext     = {x_i[DATA_W-1], x_i};
    sig_sum = (ext >>> 2) + HALF_W;
    y_o     = x_i;
    case (act_sel_i)
      ACT_RELU: begin
        if (x_i[DATA_W-1]) y_o = '0;
      end
      ACT_LEAKY: begin
        if (x_i[DATA_W-1]) y_o = x_i >>> LEAKY_SHIFT;
      end
      ACT_HSIGMOID: begin
        if (sig_sum < 0)          y_o = '0;
        else if (sig_sum > ONE_W) y_o = ONE_W[DATA_W-1:0];
        else                      y_o = sig_sum[DATA_W-1:0];
      end
      ACT_HTANH: begin
        if (ext > ONE_W)          y_o = ONE_W[DATA_W-1:0];
        else if (ext < NEG_ONE_W) y_o = NEG_ONE_W[DATA_W-1:0];
        else                      y_o = x_i;
      end
      default: y_o = x_i;
    endcase
  end

endmodule

// File: rtl/activations.sv
// Registered element-wise activation over N lanes at the systolic array output edge.
// Latency: 1 cycle, one beat per cycle.
// Backpressure: none; consumer must accept every out_valid beat.
module activations
  import act_pkg::*;
#(
  parameter int N      = 4,
  parameter int DATA_W = DEF_DATA_W,
  parameter int FRAC_W = DEF_FRAC_W
) (
  input  logic                   clk,
  input  logic                   n_rst,
  input  logic                   in_valid,
  input  logic [ACT_SEL_W-1:0]   act_sel,
  input  logic [N*DATA_W-1:0]    data_in,
  output logic                   out_valid,
  output logic [N*DATA_W-1:0]    data_out
);

  logic [N*DATA_W-1:0] lane_y;
  logic [N*DATA_W-1:0] data_d, data_q;
  logic                vld_q;

  for (genvar i = 0; i < N; i++) begin : g_lane
    act_lane #(
      .DATA_W (DATA_W),
      .FRAC_W (FRAC_W)
    ) u_lane (
      .x_i       (data_in[i*DATA_W +: DATA_W]),
      .act_sel_i (act_sel),
      .y_o       (lane_y[i*DATA_W +: DATA_W])
    );
  end

  // Capture activated lanes on a valid beat, otherwise hold the last result.
  always_comb begin
    data_d = data_q;
    if (in_valid) data_d = lane_y;
  end

  // Output registers; n_rst is synchronous and active-high, and beats in a reset cycle are dropped.
  always_ff @(posedge clk) begin
    if (n_rst) begin
      vld_q  <= 1'b0;
      data_q <= '0;
    end else begin
      vld_q  <= in_valid;
      data_q <= data_d;
    end
  end

  assign out_valid = vld_q;
  assign data_out  = data_q;

endmodule

// File: tb/tb_activations.sv
// Scoreboard bench for the activation stage: expected rows queued at drive time, compared one edge later.
// Latency: checks exactly one cycle between accepted beat and out_valid.
// Backpressure: none modelled; every valid beat must appear.
module tb_activations;

  localparam int N      = 4;
  localparam int DATA_W = 16;
  localparam int FRAC_W = 8;

  logic                clk;
  logic                n_rst;
  logic                in_valid;
  logic [2:0]          act_sel;
  logic [N*DATA_W-1:0] data_in;
  logic                out_valid;
  logic [N*DATA_W-1:0] data_out;

  int n_tests;
  int n_fail;

  logic [N*DATA_W-1:0] sb_q[$];
  logic [N*DATA_W-1:0] exp_hold;

  activations #(
    .N      (N),
    .DATA_W (DATA_W),
    .FRAC_W (FRAC_W)
  ) dut (
    .clk       (clk),
    .n_rst     (n_rst),
    .in_valid  (in_valid),
    .act_sel   (act_sel),
    .data_in   (data_in),
    .out_valid (out_valid),
    .data_out  (data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic logic [63:0] pack4(input logic [15:0] l0, input logic [15:0] l1,
                                        input logic [15:0] l2, input logic [15:0] l3);
    return {l3, l2, l1, l0};
  endfunction

  // Independent reference written with integer arithmetic, Q8.8 (ONE=256, HALF=128).
  function automatic logic [15:0] ref_lane(input logic [2:0] sel, input logic [15:0] v);
    int x;
    int y;
    logic [31:0] yb;
    x = int'($signed(v));
    case (sel)
      3'd1: y = (x < 0) ? 0 : x;
      3'd2: y = (x < 0) ? (x >>> 3) : x;
      3'd3: begin
        y = (x >>> 2) + 128;
        if (y < 0) y = 0;
        if (y > 256) y = 256;
      end
      3'd4: begin
        y = x;
        if (y > 256) y = 256;
        if (y < -256) y = -256;
      end
      default: y = x;
    endcase
    yb = y;
    return yb[15:0];
  endfunction

  function automatic logic [63:0] ref_row(input logic [2:0] sel, input logic [63:0] d);
    logic [63:0] r;
    r = '0;
    for (int i = 0; i < N; i++) r[i*16 +: 16] = ref_lane(sel, d[i*16 +: 16]);
    return r;
  endfunction

  // Drive one cycle of stimulus, then check the DUT just after the edge.
  task automatic cycle(input logic rst, input logic vld, input logic [2:0] sel,
                       input logic [63:0] dat, input logic [63:0] exp, input string tag);
    logic [63:0] e;
    n_rst    = rst;
    in_valid = vld;
    act_sel  = sel;
    data_in  = dat;
    if (!rst && vld) sb_q.push_back(exp);
    @(posedge clk);
    #1;
    if (rst) begin
      sb_q.delete();
      exp_hold = '0;
      chk({tag, "_rst_vld"}, 64'(out_valid), 64'd0);
      chk({tag, "_rst_dat"}, data_out, 64'd0);
    end else if (vld) begin
      chk({tag, "_vld"}, 64'(out_valid), 64'd1);
      chk({tag, "_sb_depth"}, 64'(sb_q.size()), 64'd1);
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        chk({tag, "_dat"}, data_out, e);
        exp_hold = e;
      end
    end else begin
      chk({tag, "_idle_vld"}, 64'(out_valid), 64'd0);
      chk({tag, "_hold_dat"}, data_out, exp_hold);
    end
  endtask

  initial begin
    logic [63:0] d;
    logic [63:0] row_a;
    n_tests  = 0;
    n_fail   = 0;
    exp_hold = '0;
    n_rst    = 1'b1;
    in_valid = 1'b1;
    act_sel  = 3'd0;
    data_in  = '0;

    // Reset dominates a valid beat.
    d = pack4(16'h1234, 16'h1234, 16'h1234, 16'h1234);
    cycle(1'b1, 1'b1, 3'd0, d, '0, "reset0");
    cycle(1'b1, 1'b1, 3'd0, d, '0, "reset1");
    cycle(1'b0, 1'b0, 3'd0, d, '0, "post_reset_idle");
    cycle(1'b0, 1'b1, 3'd0, d, d, "first_beat");

    // Directed rows with constant expectations.
    row_a = pack4(16'h0300, 16'hFD00, 16'h0000, 16'h8000);
    cycle(1'b0, 1'b1, 3'd1, row_a, pack4(16'h0300, 16'h0000, 16'h0000, 16'h0000), "relu");
    cycle(1'b0, 1'b1, 3'd0, row_a, row_a, "identity");
    cycle(1'b0, 1'b1, 3'd6, row_a, row_a, "reserved6");
    cycle(1'b0, 1'b1, 3'd2, pack4(16'hFE00, 16'hFFFF, 16'h0100, 16'hFFF8),
          pack4(16'hFFC0, 16'hFFFF, 16'h0100, 16'hFFFF), "leaky");
    cycle(1'b0, 1'b1, 3'd3, pack4(16'h0000, 16'h0400, 16'hFC00, 16'h0100),
          pack4(16'h0080, 16'h0100, 16'h0000, 16'h00C0), "hsigmoid");
    cycle(1'b0, 1'b1, 3'd4, pack4(16'h0300, 16'hFD00, 16'h0080, 16'h7FFF),
          pack4(16'h0100, 16'hFF00, 16'h0080, 16'h0100), "htanh");
    cycle(1'b0, 1'b1, 3'd3, pack4(16'h7FFF, 16'h8000, 16'hFE00, 16'h0200),
          pack4(16'h0100, 16'h0000, 16'h0000, 16'h0100), "hsig_extremes");

    // Back-to-back beats, every select code in turn, mixed random and edge data.
    for (int i = 0; i < 8; i++) begin
      d = {$urandom(), $urandom()};
      if (i == 3) d = pack4(16'h8000, 16'h7FFF, 16'hFFFF, 16'h0001);
      cycle(1'b0, 1'b1, 3'(i), d, ref_row(3'(i), d), "stream");
    end

    // Gap: output valid drops, data holds.
    cycle(1'b0, 1'b0, 3'd1, 64'hDEAD_BEEF_0BAD_F00D, '0, "gap0");
    cycle(1'b0, 1'b0, 3'd4, 64'h0123_4567_89AB_CDEF, '0, "gap1");

    // Resume, then reset mid-stream; no stale beat may surface afterwards.
    for (int i = 0; i < 3; i++) begin
      d = {$urandom(), $urandom()};
      cycle(1'b0, 1'b1, 3'(i + 2), d, ref_row(3'(i + 2), d), "resume");
    end
    d = {$urandom(), $urandom()};
    cycle(1'b1, 1'b1, 3'd2, d, '0, "mid_reset");
    cycle(1'b0, 1'b0, 3'd2, d, '0, "after_reset");
    d = pack4(16'hFD00, 16'h0300, 16'h8000, 16'h0040);
    cycle(1'b0, 1'b1, 3'd1, d, pack4(16'h0000, 16'h0300, 16'h0000, 16'h0040), "restart");
    cycle(1'b0, 1'b0, 3'd0, '0, '0, "tail");

    chk("sb_drained", 64'(sb_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/activations.md
Name: activations

Overview:
- Registered, element-wise activation stage at the output edge of the systolic array.
- Takes one row of N signed fixed-point accumulator results per cycle and applies a selectable piecewise-linear activation to every lane.
- Presents the result one clock later with a valid flag.
- No backpressure: the downstream consumer (output buffer/writeback) must accept every valid beat.

Parameters:
- N, 4, number of lanes (array columns) processed in parallel.
- DATA_W, 16, lane width; signed two's complement fixed point.
- FRAC_W, 8, fractional bits (default Q8.8, so 1.0 = 0x0100).

Ports:
- clk  input  1  system clock, all state on rising edge.
- n_rst  input  1  synchronous reset, active-high (asserted = 1) despite the codebase name; sampled on rising clk.
- in_valid  input  1  data_in/act_sel valid this cycle.
- act_sel  input  3  activation select, sampled with data_in.
- data_in  input  N*DATA_W  packed lanes; lane i at bits [i*DATA_W +: DATA_W].
- out_valid  output  1  data_out valid.
- data_out  output  N*DATA_W  packed activated lanes, same packing as data_in.

Behaviour:
- Reset (n_rst=1 at a rising edge):
  - out_valid<=0 and data_out<=0.
  - Any beat presented that cycle is dropped.
  - Reset dominates in_valid.
- Latency: exactly 1 cycle. A beat accepted at edge k appears at edge k with out_valid=1 for one cycle, i.e. it is visible after edge k.
- Throughput: one beat per cycle; back-to-back beats produce back-to-back outputs.
- in_valid=0: out_valid<=0 and data_out holds its previous value. Act_sel and data_in are ignored.
- act_sel is applied per beat; changing it between beats affects only the beats that carry the new value.
- One ONE constant = 1<<FRAC_W, and one HALF constant = ONE>>1. Per lane, x signed DATA_W:
  - 0 IDENTITY: y = x.
  - 1 RELU: y = (x<0) ? 0 : x.
  - 2 LEAKY_RELU: y = (x<0) ? (x>>>3) : x. Arithmetic shift, floor rounding, so -1 -> -1.
  - 3 HARD_SIGMOID: y = clamp((x>>>2) + HALF, 0, ONE). Compute in DATA_W+1 bits so the sum cannot overflow before clamping.
  - 4 HARD_TANH: y = clamp(x, -ONE, +ONE).
  - 5-7 reserved: behave as IDENTITY.
- All lanes use the same act_sel in a given cycle. Lanes are independent, with no cross-lane arithmetic.
- Saturation bounds are inclusive:
  - x = -32768 under RELU gives 0.
  - x = 32767 under HARD_TANH gives 0x0100.
- No X propagation from reserved codes.
- Outputs are driven only from flops.

Decomposition:
- Shared package act_pkg holds:
  - act_sel_t enum: ACT_IDENTITY=0, ACT_RELU, ACT_LEAKY, ACT_HSIGMOID, ACT_HTANH.
  - Default DATA_W/FRAC_W localparams.
  - LEAKY_SHIFT=3.
- One sub-module, act_lane: purely combinational single-lane function (x, act_sel -> y).
  - Instantiated N times by generate.
  - Top holds only the input mux/registers and the valid flop.

Test Plan:
- Reset: hold n_rst=1 for 2 cycles while driving in_valid=1, data 0x1234 -> out_valid=0, data_out=0. Deassert, then a single beat appears 1 cycle later.
- RELU/IDENTITY, N=4, lanes {0x0300, 0xFD00, 0x0000, 0x8000}:
  - sel=1 -> {0x0300, 0x0000, 0x0000, 0x0000}.
  - sel=0 -> unchanged.
  - sel=6 -> unchanged.
- LEAKY, lanes {0xFE00, 0xFFFF, 0x0100, 0xFFF8} -> {0xFFC0, 0xFFFF, 0x0100, 0xFFFF}.
- HARD_SIGMOID, lanes {0x0000, 0x0400, 0xFC00, 0x0100} -> {0x0080, 0x0100, 0x0000, 0x00C0}.
- HARD_TANH, lanes {0x0300, 0xFD00, 0x0080, 0x7FFF} -> {0x0100, 0xFF00, 0x0080, 0x0100}.
- Streaming: 8 back-to-back beats with alternating act_sel, then an in_valid gap, then a reset asserted mid-stream.
  - Each output is 1-cycle delayed and uses its own sel.
  - The gap gives out_valid=0 with data_out held.
  - The mid-stream reset clears outputs the next edge; no stale beat emerges after reset.
